// File: rtl/spi2axi_burst.sv
// SPI mode-0 slave bridging burst frames onto an AXI4-Lite master.
// SPI pins are oversampled in the AXI clock domain.
module spi2axi_burst #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DUMMY_BITS = 8
) (
  input  logic                  axi_clk_i,
  input  logic                  axi_rstn_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_ss_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [2:0]            axi_awprot,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic [2:0]            axi_arprot,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic                  busy_o,
  output logic [3:0]            err_o
);

  localparam int SW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MX = (SW > DUMMY_BITS) ? SW : DUMMY_BITS;
  localparam int CW = $clog2(MX + 1);

  localparam logic [CW-1:0] CMD_L = CW'(7);
  localparam logic [CW-1:0] ADR_L = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] DAT_L = CW'(DATA_W - 1);
  localparam logic [CW-1:0] DMY_L = CW'(DUMMY_BITS - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, DRAIN
  } state_t;

  state_t              state;
  logic [2:0]          sck_q;
  logic [2:0]          ss_q;
  logic [1:0]          mosi_q;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       rx;
  logic [SW-1:0]       rx_nxt;
  logic                wr;
  logic                inc;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   step;
  logic [DATA_W-1:0]   tx;
  logic [DATA_W-1:0]   pf;
  logic                pf_v;
  logic [DATA_W-1:0]   ld_word;
  logic                sck_rise;
  logic                sck_fall;
  logic                ss_fall;
  logic                ss_rise;
  logic                wr_out;
  logic                rd_out;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_fall  = ~ss_q[1] & ss_q[2];
  assign ss_rise  = ss_q[1] & ~ss_q[2];
  assign rx_nxt   = {rx[SW-2:0], mosi_q[1]};
  assign wr_out   = axi_awvalid | axi_wvalid | axi_bready;
  assign rd_out   = axi_arvalid | axi_rready;
  assign step     = inc ? STEP : '0;
  assign ld_word  = pf_v ? pf : '0;

  assign spi_miso_oe_o = ~ss_q[1];
  assign busy_o        = (state != IDLE) | wr_out | rd_out;
  assign axi_awprot    = 3'b000;
  assign axi_arprot    = 3'b000;
  assign axi_wstrb     = '1;

  always_ff @(posedge axi_clk_i) begin
    if (!axi_rstn_i) begin
      state       <= IDLE;
      sck_q       <= '0;
      ss_q        <= '1;
      mosi_q      <= '0;
      cnt         <= '0;
      rx          <= '0;
      wr          <= 1'b0;
      inc         <= 1'b0;
      addr        <= '0;
      tx          <= '0;
      pf          <= '0;
      pf_v        <= 1'b0;
      err_o       <= '0;
      spi_miso_o  <= 1'b0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck_i};
      ss_q   <= {ss_q[1:0], spi_ss_n_i};
      mosi_q <= {mosi_q[0], spi_mosi_i};

      if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
      if (axi_wvalid && axi_wready) axi_wvalid <= 1'b0;
      if (axi_arvalid && axi_arready) axi_arvalid <= 1'b0;
      if (axi_bready && axi_bvalid) begin
        axi_bready <= 1'b0;
        if (axi_bresp != 2'b00) err_o[0] <= 1'b1;
      end

      if (ss_rise && state != IDLE) begin
        state <= DRAIN;
      end else begin
        unique case (state)
          IDLE: if (ss_fall) begin
            state <= CMD;
            cnt   <= '0;
            err_o <= '0;
          end
          CMD: if (sck_rise) begin
            rx  <= rx_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CMD_L) begin
              wr    <= rx_nxt[7];
              inc   <= rx_nxt[6];
              cnt   <= '0;
              state <= ADDR;
            end
          end
          ADDR: if (sck_rise) begin
            rx  <= rx_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == ADR_L) begin
              cnt <= '0;
              if (wr) begin
                addr  <= rx_nxt[ADDR_W-1:0];
                state <= WDATA;
              end else begin
                axi_araddr  <= rx_nxt[ADDR_W-1:0];
                axi_arvalid <= 1'b1;
                axi_rready  <= 1'b1;
                addr        <= rx_nxt[ADDR_W-1:0] + step;
                state       <= RDUMMY;
              end
            end
          end
          WDATA: if (sck_rise) begin
            rx  <= rx_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == DAT_L) begin
              cnt <= '0;
              if (wr_out) begin
                err_o[2] <= 1'b1;
              end else begin
                axi_awaddr  <= addr;
                axi_wdata   <= rx_nxt[DATA_W-1:0];
                axi_awvalid <= 1'b1;
                axi_wvalid  <= 1'b1;
                axi_bready  <= 1'b1;
                addr        <= addr + step;
              end
            end
          end
          RDUMMY: if (sck_rise) begin
            cnt <= cnt + 1'b1;
            if (cnt == DMY_L) begin
              cnt   <= '0;
              state <= RDATA;
            end
          end
          RDATA: begin
            if (sck_rise) begin
              cnt <= (cnt == DAT_L) ? '0 : cnt + 1'b1;
            end else if (sck_fall) begin
              // word boundary: present the prefetch and refill it
              if (cnt == '0) begin
                spi_miso_o <= ld_word[DATA_W-1];
                tx         <= {ld_word[DATA_W-2:0], 1'b0};
                pf_v       <= 1'b0;
                if (!pf_v) err_o[3] <= 1'b1;
                if (!rd_out) begin
                  axi_araddr  <= addr;
                  axi_arvalid <= 1'b1;
                  axi_rready  <= 1'b1;
                  addr        <= addr + step;
                end
              end else begin
                spi_miso_o <= tx[DATA_W-1];
                tx         <= {tx[DATA_W-2:0], 1'b0};
              end
            end
          end
          DRAIN: if (!wr_out && !rd_out) begin
            state      <= IDLE;
            spi_miso_o <= 1'b0;
            pf_v       <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end

      // late capture wins over the load-time clear of the prefetch
      if (axi_rready && axi_rvalid) begin
        axi_rready <= 1'b0;
        pf         <= axi_rdata;
        pf_v       <= 1'b1;
        if (axi_rresp != 2'b00) err_o[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi2axi_burst.sv
// Bench for spi2axi_burst: SPI host, AXI-Lite slave and frame-level model.
// Expected bus traffic and read data are derived from frame contents.
module tb_spi2axi_burst;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DB = 8;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          spi_sck;
  logic          spi_ss_n;
  logic          spi_mosi;
  logic          spi_miso_o;
  logic          spi_miso_oe_o;
  logic [AW-1:0] axi_awaddr;
  logic [2:0]    axi_awprot;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [DW-1:0] axi_wdata;
  logic [3:0]    axi_wstrb;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [AW-1:0] axi_araddr;
  logic [2:0]    axi_arprot;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rvalid;
  logic          axi_rready;
  logic          busy_o;
  logic [3:0]    err_o;

  always #5 clk = ~clk;

  spi2axi_burst #(.ADDR_W(AW), .DATA_W(DW), .DUMMY_BITS(DB)) dut (
    .axi_clk_i(clk), .axi_rstn_i(rstn),
    .spi_sck_i(spi_sck), .spi_ss_n_i(spi_ss_n), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .busy_o(busy_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  int         b_dly  = 1;
  int         ar_dly = -1;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;

  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [3:0]  s_q[$];
  logic [31:0] ar_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] rd_a;

  logic [31:0] wbuf[4];
  logic [31:0] rbuf[4];
  logic        oe_mid;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [31:0] got[$],
                         input logic [31:0] exp[$]);
    check({tag, "_n"}, 64'(got.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < got.size())
        check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
  endtask

  // AXI-Lite write slave: AW then W, then B after b_dly cycles
  initial begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (axi_awvalid) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        axi_awready = 1'b1;
        aw_q.push_back(axi_awaddr);
        @(negedge clk);
        axi_awready = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        axi_wready = 1'b1;
        w_q.push_back(axi_wdata);
        s_q.push_back(axi_wstrb);
        @(negedge clk);
        axi_wready = 1'b0;
        repeat (b_dly) @(negedge clk);
        axi_bvalid = 1'b1;
        axi_bresp  = bresp_cfg;
        while (!axi_bready) @(negedge clk);
        @(negedge clk);
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
      end
    end
  end

  // AXI-Lite read slave: data is a function of the address
  initial begin
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (axi_arvalid) begin
        repeat (ar_dly >= 0 ? ar_dly : int'($urandom_range(0, 3)))
          @(negedge clk);
        axi_arready = 1'b1;
        rd_a = axi_araddr;
        ar_q.push_back(rd_a);
        @(negedge clk);
        axi_arready = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        axi_rvalid = 1'b1;
        axi_rdata  = data_of(rd_a);
        axi_rresp  = rresp_cfg;
        while (!axi_rready) @(negedge clk);
        @(negedge clk);
        axi_rvalid = 1'b0;
        axi_rresp  = 2'b00;
      end
    end
  end

  // SPI host, mode 0; SCK returns low together with SS_N rising
  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr,
                           input int ndbits);
    int  nb;
    int  k;
    logic b;
    logic rd;
    rd = ~cmd[7];
    nb = 8 + AW + (rd ? DB : 0) + ndbits;
    for (int j = 0; j < 4; j++) rbuf[j] = '0;
    spi_ss_n = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i < 8) b = cmd[7-i];
      else if (i < 8 + AW) b = addr[AW-1-(i-8)];
      else if (!rd) begin
        k = i - 8 - AW;
        b = wbuf[k/DW][DW-1-(k%DW)];
      end else b = 1'b0;
      spi_mosi = b;
      repeat (H) @(negedge clk);
      if (i == 0) oe_mid = spi_miso_oe_o;
      if (rd && i >= 8 + AW + DB) begin
        k = i - 8 - AW - DB;
        rbuf[k/DW][DW-1-(k%DW)] = spi_miso_o;
      end
      spi_sck = 1'b1;
      repeat (H) @(negedge clk);
      spi_sck = 1'b0;
      if (i == nb - 1) spi_ss_n = 1'b1;
    end
    spi_ss_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy_o && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check(tag, busy_o, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_write(input string tag, input logic [7:0] cmd,
                           input logic [31:0] addr, input int nbits,
                           input int nexp, input logic [3:0] exp_err);
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [31:0] stp;
    stp = cmd[6] ? 32'd4 : 32'd0;
    for (int k = 0; k < nexp; k++) begin
      ea.push_back(addr + 32'(k) * stp);
      ed.push_back(wbuf[k]);
    end
    aw_q.delete();
    w_q.delete();
    s_q.delete();
    spi_frame(cmd, addr, nbits);
    wait_idle({tag, "_idle"});
    check_q({tag, "_awaddr"}, aw_q, ea);
    check_q({tag, "_wdata"}, w_q, ed);
    foreach (s_q[i]) check({tag, "_wstrb"}, s_q[i], 4'hF);
    check({tag, "_oe"}, oe_mid, 1'b1);
    check({tag, "_err"}, err_o, exp_err);
  endtask

  task automatic run_read(input string tag, input logic [7:0] cmd,
                          input logic [31:0] addr, input int n,
                          input logic [3:0] exp_err);
    logic [31:0] ea[$];
    logic [31:0] stp;
    stp = cmd[6] ? 32'd4 : 32'd0;
    for (int k = 0; k <= n; k++) ea.push_back(addr + 32'(k) * stp);
    ar_q.delete();
    spi_frame(cmd, addr, n * DW);
    wait_idle({tag, "_idle"});
    check_q({tag, "_araddr"}, ar_q, ea);
    for (int k = 0; k < n; k++)
      check($sformatf("%s_rdata%0d", tag, k), rbuf[k],
            data_of(addr + 32'(k) * stp));
    check({tag, "_err"}, err_o, exp_err);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [31:0] ua;
  logic [7:0]  rc;
  logic [31:0] ra;
  int          rn;

  initial begin
    rstn     = 1'b0;
    spi_sck  = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid,
                         axi_bready, axi_rready}, 5'b0);
    check("rst_spi", {spi_miso_o, spi_miso_oe_o}, 2'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 4'h0);

    wbuf[0] = 32'hDEAD_BEEF;
    run_write("single", 8'h80, 32'h0000_0010, DW, 1, 4'h0);

    b_dly = 2;
    wbuf[0] = 32'hA5A5_0001;
    wbuf[1] = 32'h5A5A_0002;
    wbuf[2] = 32'h1234_5678;
    run_write("burst_w", 8'hC0, 32'h0000_0100, 3 * DW, 3, 4'h0);
    b_dly = 1;

    mem[32'h200] = 32'h1111_1111;
    mem[32'h204] = 32'h2222_2222;
    run_read("burst_r", 8'h40, 32'h0000_0200, 2, 4'h0);

    bresp_cfg = 2'b10;
    wbuf[0] = 32'h0BAD_0BAD;
    run_write("bresp", 8'h80, 32'h0000_0040, DW, 1, 4'b0001);
    bresp_cfg = 2'b00;
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
    check("err_clear", err_o, 4'h0);
    spi_ss_n = 1'b1;
    wait_idle("err_clear_idle");

    rresp_cfg = 2'b10;
    run_read("rresp", 8'h40, 32'h0000_0500, 1, 4'b0010);
    rresp_cfg = 2'b00;

    wbuf[0] = 32'hFFFF_FFFF;
    run_write("abort", 8'h80, 32'h0000_0080, 20, 0, 4'h0);

    b_dly = 400;
    wbuf[0] = 32'hCAFE_0001;
    wbuf[1] = 32'hCAFE_0002;
    run_write("overflow", 8'hC0, 32'h0000_0300, 2 * DW, 1, 4'b0100);
    b_dly = 1;

    wbuf[0] = 32'h0000_AAAA;
    wbuf[1] = 32'h0000_BBBB;
    run_write("wrap", 8'hC0, 32'hFFFF_FFFC, 2 * DW, 2, 4'h0);

    ar_dly = 200;
    ua = 32'h0000_0A00;
    ar_q.delete();
    spi_frame(8'h40, ua, 2 * DW);
    wait_idle("under_idle");
    check("under_w0", rbuf[0], 32'h0);
    check("under_w1", rbuf[1], data_of(ua));
    check_q("under_ar", ar_q, '{ua, ua + 32'd4});
    check("under_err", err_o, 4'b1000);
    ar_dly = -1;

    for (int r = 0; r < 6; r++) begin
      rc = {1'($urandom), 1'($urandom), 6'($urandom)};
      ra = $urandom;
      rn = $urandom_range(1, 3);
      if (rc[7]) begin
        for (int k = 0; k < 4; k++) wbuf[k] = $urandom;
        run_write($sformatf("rnd%0d_w", r), rc, ra, rn * DW, rn, 4'h0);
      end else begin
        run_read($sformatf("rnd%0d_r", r), rc, ra, rn, 4'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
